// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter-update encoding and index sizing.
package bp_pkg;

  // Direction applied to a saturating counter on a resolved branch.
  typedef enum logic {
    CntDec = 1'b0,
    CntInc = 1'b1
  } cnt_op_e;

  // Weakly-not-taken reset encoding for a counter of the given width.
  function automatic int unsigned bp_cnt_rst(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

  // Number of index bits needed to address a table of the given size.
  function automatic int unsigned bp_idx_w(input int unsigned entries);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << w) < entries) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bp_sat_update.sv
// Saturating up/down next-value logic for one prediction counter.
module bp_sat_update
  import bp_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             taken_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntMin = '0;

  cnt_op_e op;

  assign op = taken_i ? CntInc : CntDec;

  always_comb begin
    cnt_o = cnt_i;
    unique case (op)
      CntInc: if (cnt_i != CntMax) cnt_o = cnt_i + CNT_W'(1);
      CntDec: if (cnt_i != CntMin) cnt_o = cnt_i - CNT_W'(1);
      default: cnt_o = cnt_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal saturating-counter branch predictor with resolution statistics.
// Define GSHARE_EN to XOR a global history register into the table index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned GHR_W   = 4,
  parameter int unsigned STAT_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall_i,
  input  logic [PC_W-1:0]               if_pc_i,
  input  logic                          if_is_branch_i,
  output logic                          pred_taken_o,
  output logic [bp_idx_w(ENTRIES)-1:0]  pred_idx_o,
  input  logic                          upd_valid_i,
  input  logic [bp_idx_w(ENTRIES)-1:0]  upd_idx_i,
  input  logic                          upd_taken_i,
  input  logic                          upd_pred_i,
  output logic                          mispredict_o,
  output logic [STAT_W-1:0]             branch_cnt_o,
  output logic [STAT_W-1:0]             miss_cnt_o
);

  localparam int unsigned      IDX_W  = bp_idx_w(ENTRIES);
  localparam logic [CNT_W-1:0] CntRst = CNT_W'(bp_cnt_rst(CNT_W));

  if (ENTRIES < 2 || (32'd1 << IDX_W) != ENTRIES) begin : g_bad_entries
    $error("ENTRIES must be a power of two and at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
  if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr_w
    $error("GHR_W must be between 1 and IDX_W");
  end
  if (PC_W <= IDX_W + 2) begin : g_bad_pc_w
    $error("PC_W must exceed IDX_W + 2");
  end

  logic             upd_en;
  logic [IDX_W-1:0] base_idx;
  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [CNT_W-1:0] cnt_upd;

  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Byte-offset bits and PC bits above the index do not participate.
  logic unused_pc;
  assign unused_pc = ^{if_pc_i[PC_W-1:IDX_W+2], if_pc_i[1:0]};

  assign upd_en       = upd_valid_i & ~stall_i;
  assign base_idx     = if_pc_i[IDX_W+1:2];
  assign mispredict_o = upd_valid_i & (upd_taken_i ^ upd_pred_i);

`ifdef GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  assign pred_idx_o = base_idx ^ IDX_W'(ghr_q);
  // Oldest outcome falls off the top; newest enters at bit 0.
  assign ghr_d      = GHR_W'({ghr_q, upd_taken_i});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (upd_en) begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign pred_idx_o = base_idx;
`endif

  // Prediction reads the registered table directly, so a same-cycle update is not seen.
  assign pred_taken_o = cnt_q[pred_idx_o][CNT_W-1] & if_is_branch_i;

  bp_sat_update #(
    .CNT_W (CNT_W)
  ) u_sat_update (
    .cnt_i   (cnt_q[upd_idx_i]),
    .taken_i (upd_taken_i),
    .cnt_o   (cnt_upd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        cnt_q[i] <= CntRst;
      end
    end else if (upd_en) begin
      cnt_q[upd_idx_i] <= cnt_upd;
    end
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (upd_en) begin
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + STAT_W'(1);
      if (mispredict_o && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign branch_cnt_o = branch_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, CNT_W=2, STAT_W=32).
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned GHR_W   = 4;
  localparam int unsigned STAT_W  = 32;
  localparam int unsigned IDX_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stall_i = 1'b0;
  logic [PC_W-1:0]   if_pc_i = '0;
  logic              if_is_branch_i = 1'b1;
  logic              pred_taken_o;
  logic [IDX_W-1:0]  pred_idx_o;
  logic              upd_valid_i = 1'b0;
  logic [IDX_W-1:0]  upd_idx_i = '0;
  logic              upd_taken_i = 1'b0;
  logic              upd_pred_i = 1'b0;
  logic              mispredict_o;
  logic [STAT_W-1:0] branch_cnt_o;
  logic [STAT_W-1:0] miss_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [STAT_W-1:0] exp_br   = '0;
  logic [STAT_W-1:0] exp_miss = '0;

  branch_predictor #(
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W),
    .PC_W    (PC_W),
    .GHR_W   (GHR_W),
    .STAT_W  (STAT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .if_pc_i        (if_pc_i),
    .if_is_branch_i (if_is_branch_i),
    .pred_taken_o   (pred_taken_o),
    .pred_idx_o     (pred_idx_o),
    .upd_valid_i    (upd_valid_i),
    .upd_idx_i      (upd_idx_i),
    .upd_taken_i    (upd_taken_i),
    .upd_pred_i     (upd_pred_i),
    .mispredict_o   (mispredict_o),
    .branch_cnt_o   (branch_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
  );

  always #5 clk = ~clk;

  // Drive one resolved branch across a single rising edge and track expected statistics.
  task automatic upd(input logic [IDX_W-1:0] idx, input logic taken, input logic pred);
    @(negedge clk);
    upd_valid_i = 1'b1;
    upd_idx_i   = idx;
    upd_taken_i = taken;
    upd_pred_i  = pred;
    @(posedge clk);
    if (!stall_i) begin
      exp_br = exp_br + 1;
      if (taken != pred) exp_miss = exp_miss + 1;
    end
    #1;
    upd_valid_i = 1'b0;
  endtask

  task automatic set_pc(input logic [PC_W-1:0] pc);
    if_pc_i = pc;
    #1;
  endtask

  task automatic test_reset();
    set_pc(32'h40);
    total++;
    if (pred_idx_o !== 4'd0) begin
      bad++; $display("FAIL reset_idx got=%0d want=0", pred_idx_o);
    end
    total++;
    if (pred_taken_o !== 1'b0) begin
      bad++; $display("FAIL reset_pred got=%b want=0", pred_taken_o);
    end
    total++;
    if (branch_cnt_o !== '0 || miss_cnt_o !== '0) begin
      bad++; $display("FAIL reset_stats got=%0d/%0d want=0/0", branch_cnt_o, miss_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_pc(32'hFFFF_FF3C);
    total++;
    if (pred_idx_o !== 4'd15) begin
      bad++; $display("FAIL index_high_pc got=%0d want=15", pred_idx_o);
    end
  endtask

  task automatic test_taken_sat();
    logic [3:0] exp_p;
    exp_p = 4'b1110;  // taken prediction after each step below
    set_pc(32'h0C);
    total++;
    if (pred_idx_o !== 4'd3 || pred_taken_o !== 1'b0) begin
      bad++; $display("FAIL idx3_init got=%0d/%b want=3/0", pred_idx_o, pred_taken_o);
    end
    upd(4'd3, 1'b1, 1'b0);  // 01 -> 10
    set_pc(32'h0C);
    total++;
    if (pred_taken_o !== 1'b1) begin
      bad++; $display("FAIL idx3_taken1 got=%b want=1", pred_taken_o);
    end
    upd(4'd3, 1'b1, 1'b1);  // 10 -> 11
    set_pc(32'h0C);
    total++;
    if (pred_taken_o !== exp_p[3]) begin
      bad++; $display("FAIL idx3_taken2 got=%b want=%b", pred_taken_o, exp_p[3]);
    end
    upd(4'd3, 1'b1, 1'b1);  // stays 11
    upd(4'd3, 1'b0, 1'b1);  // 11 -> 10
    set_pc(32'h0C);
    total++;
    if (pred_taken_o !== exp_p[2]) begin
      bad++; $display("FAIL idx3_sat_hi got=%b want=%b", pred_taken_o, exp_p[2]);
    end
    upd(4'd3, 1'b0, 1'b1);  // 10 -> 01
    set_pc(32'h0C);
    total++;
    if (pred_taken_o !== exp_p[0]) begin
      bad++; $display("FAIL idx3_back_01 got=%b want=%b", pred_taken_o, exp_p[0]);
    end
    total++;
    if (branch_cnt_o !== 32'd5 || miss_cnt_o !== 32'd3) begin
      bad++; $display("FAIL stats_after_idx3 got=%0d/%0d want=5/3", branch_cnt_o, miss_cnt_o);
    end
  endtask

  task automatic test_not_taken_sat();
    upd(4'd5, 1'b0, 1'b0);  // 01 -> 00
    upd(4'd5, 1'b0, 1'b0);  // stays 00
    set_pc(32'h14);
    total++;
    if (pred_idx_o !== 4'd5 || pred_taken_o !== 1'b0) begin
      bad++; $display("FAIL idx5_sat_lo got=%0d/%b want=5/0", pred_idx_o, pred_taken_o);
    end
    upd(4'd5, 1'b1, 1'b0);  // 00 -> 01
    set_pc(32'h14);
    total++;
    if (pred_taken_o !== 1'b0) begin
      bad++; $display("FAIL idx5_after_inc got=%b want=0", pred_taken_o);
    end
    upd(4'd5, 1'b1, 1'b0);  // 01 -> 10
    set_pc(32'h14);
    total++;
    if (pred_taken_o !== 1'b1) begin
      bad++; $display("FAIL idx5_after_inc2 got=%b want=1", pred_taken_o);
    end
    if_is_branch_i = 1'b0;
    #1;
    total++;
    if (pred_taken_o !== 1'b0) begin
      bad++; $display("FAIL not_branch_gate got=%b want=0", pred_taken_o);
    end
    if_is_branch_i = 1'b1;
    #1;
  endtask

  task automatic test_mispredict_stats();
    @(negedge clk);
    upd_valid_i = 1'b1;
    upd_idx_i   = 4'd9;
    upd_taken_i = 1'b1;
    upd_pred_i  = 1'b0;
    #1;
    total++;
    if (mispredict_o !== 1'b1) begin
      bad++; $display("FAIL mispredict_comb got=%b want=1", mispredict_o);
    end
    upd_pred_i = 1'b1;
    #1;
    total++;
    if (mispredict_o !== 1'b0) begin
      bad++; $display("FAIL mispredict_match got=%b want=0", mispredict_o);
    end
    upd_pred_i = 1'b0;
    @(posedge clk);
    exp_br   = exp_br + 1;
    exp_miss = exp_miss + 1;
    #1;
    upd_valid_i = 1'b0;
    #1;
    total++;
    if (mispredict_o !== 1'b0) begin
      bad++; $display("FAIL mispredict_invalid got=%b want=0", mispredict_o);
    end
    total++;
    if (branch_cnt_o !== exp_br || miss_cnt_o !== exp_miss) begin
      bad++; $display("FAIL stats_count got=%0d/%0d want=%0d/%0d",
                      branch_cnt_o, miss_cnt_o, exp_br, exp_miss);
    end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    @(negedge clk);
    upd_valid_i = 1'b1;
    upd_idx_i   = 4'd7;
    upd_taken_i = 1'b1;
    upd_pred_i  = 1'b0;
    #1;
    total++;
    if (mispredict_o !== 1'b1) begin
      bad++; $display("FAIL stall_mispredict got=%b want=1", mispredict_o);
    end
    @(posedge clk);
    #1;
    upd_valid_i = 1'b0;
    set_pc(32'h1C);
    total++;
    if (pred_taken_o !== 1'b0) begin
      bad++; $display("FAIL stall_table got=%b want=0", pred_taken_o);
    end
    total++;
    if (branch_cnt_o !== exp_br || miss_cnt_o !== exp_miss) begin
      bad++; $display("FAIL stall_stats got=%0d/%0d want=%0d/%0d",
                      branch_cnt_o, miss_cnt_o, exp_br, exp_miss);
    end
    stall_i = 1'b0;
  endtask

  task automatic test_no_bypass();
    @(negedge clk);
    if_pc_i     = 32'h1C;
    upd_valid_i = 1'b1;
    upd_idx_i   = 4'd7;
    upd_taken_i = 1'b1;
    upd_pred_i  = 1'b0;
    #1;
    total++;
    if (pred_taken_o !== 1'b0) begin
      bad++; $display("FAIL no_bypass_same_cycle got=%b want=0", pred_taken_o);
    end
    @(posedge clk);
    exp_br   = exp_br + 1;
    exp_miss = exp_miss + 1;
    #1;
    upd_valid_i = 1'b0;
    #1;
    total++;
    if (pred_taken_o !== 1'b1) begin
      bad++; $display("FAIL update_next_cycle got=%b want=1", pred_taken_o);
    end
  endtask

  task automatic test_no_valid();
    @(negedge clk);
    upd_valid_i = 1'b0;
    upd_idx_i   = 4'd7;
    upd_taken_i = 1'b0;
    upd_pred_i  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    set_pc(32'h1C);
    total++;
    if (pred_taken_o !== 1'b1) begin
      bad++; $display("FAIL no_valid_table got=%b want=1", pred_taken_o);
    end
    total++;
    if (branch_cnt_o !== exp_br || miss_cnt_o !== exp_miss) begin
      bad++; $display("FAIL no_valid_stats got=%0d/%0d want=%0d/%0d",
                      branch_cnt_o, miss_cnt_o, exp_br, exp_miss);
    end
  endtask

  task automatic test_async_reset();
    upd(4'd3, 1'b1, 1'b0);  // 01 -> 10
    upd(4'd3, 1'b1, 1'b1);  // 10 -> 11
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (branch_cnt_o !== '0 || miss_cnt_o !== '0) begin
      bad++; $display("FAIL async_reset_stats got=%0d/%0d want=0/0", branch_cnt_o, miss_cnt_o);
    end
    set_pc(32'h0C);
    total++;
    if (pred_taken_o !== 1'b0) begin
      bad++; $display("FAIL async_reset_table got=%b want=0", pred_taken_o);
    end
    // An update held across an edge while in reset must be ignored.
    upd_valid_i = 1'b1;
    upd_idx_i   = 4'd3;
    upd_taken_i = 1'b1;
    upd_pred_i  = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (pred_taken_o !== 1'b0 || branch_cnt_o !== '0) begin
      bad++; $display("FAIL reset_overrides got=%b/%0d want=0/0", pred_taken_o, branch_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    upd_valid_i = 1'b0;
    exp_br   = 1;
    exp_miss = 1;
    #1;
    total++;
    if (pred_taken_o !== 1'b1 || branch_cnt_o !== exp_br || miss_cnt_o !== exp_miss) begin
      bad++; $display("FAIL first_update_after_reset got=%b/%0d/%0d want=1/%0d/%0d",
                      pred_taken_o, branch_cnt_o, miss_cnt_o, exp_br, exp_miss);
    end
    upd(4'd3, 1'b0, 1'b1);  // 10 -> 01, proves the counter restarted from 01
    set_pc(32'h0C);
    total++;
    if (pred_taken_o !== 1'b0) begin
      bad++; $display("FAIL reset_value_01 got=%b want=0", pred_taken_o);
    end
  endtask

`ifdef GSHARE_EN
  task automatic test_gshare();
    upd(4'd1, 1'b1, 1'b0);
    upd(4'd2, 1'b1, 1'b0);
    set_pc(32'h00);
    total++;
    if (pred_idx_o !== 4'd3) begin
      bad++; $display("FAIL gshare_idx got=%0d want=3", pred_idx_o);
    end
    set_pc(32'h0C);
    total++;
    if (pred_idx_o !== 4'd0) begin
      bad++; $display("FAIL gshare_idx_xor got=%0d want=0", pred_idx_o);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef GSHARE_EN
    test_gshare();
`else
    test_taken_sat();
    test_not_taken_sat();
    test_mispredict_stats();
    test_stall();
    test_no_bypass();
    test_no_valid();
    test_async_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: number of counter entries; power of two, at least 2; IDX_W = log2(ENTRIES).
REQ-002 SHALL have parameter CNT_W, default 2: width of each saturating counter, at least 1.
REQ-003 SHALL have parameter PC_W, default 32: width of the fetch PC.
REQ-004 SHALL have parameter GHR_W, default 4: global history width, at most IDX_W.
REQ-005 SHALL have parameter STAT_W, default 32: width of the statistics counters.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 stall_i  input  1  pipeline stall (ICACHE_stall | DCACHE_stall); freezes all state.
REQ-009 if_pc_i  input  PC_W  PC of the instruction in IF.
REQ-010 if_is_branch_i  input  1  predecode flag: the IF instruction is a conditional branch.
REQ-011 pred_taken_o  output  1  combinational prediction for the IF instruction.
REQ-012 pred_idx_o  output  IDX_W  table index used for the prediction; carried down the pipeline with the instruction.
REQ-013 upd_valid_i  input  1  a conditional branch is resolved in ID this cycle.
REQ-014 upd_idx_i  input  IDX_W  index that was captured at prediction time.
REQ-015 upd_taken_i  input  1  actual branch outcome.
REQ-016 upd_pred_i  input  1  prediction that was made for this branch.
REQ-017 mispredict_o  output  1  combinational; high when upd_valid_i=1 and upd_taken_i != upd_pred_i.
REQ-018 branch_cnt_o  output  STAT_W  registered count of resolved branches.
REQ-019 miss_cnt_o  output  STAT_W  registered count of mispredictions.

Function
REQ-020 Base index SHALL be if_pc_i[IDX_W+1:2] (word-aligned PC).
REQ-021 pred_taken_o SHALL be the MSB of counter[pred_idx_o] AND if_is_branch_i.
REQ-022 Counter update SHALL occur on a clock edge with upd_valid_i=1 and stall_i=0.
  - Taken: counter[upd_idx_i] increments, saturating at 2^CNT_W-1.
  - Not taken: counter[upd_idx_i] decrements, saturating at 0.
REQ-023 A prediction read and an update to the same index in the same cycle SHALL return the pre-update value (no bypass).
REQ-024 On each update edge, branch_cnt_o SHALL increment by 1 and miss_cnt_o SHALL increment by 1 when mispredict_o=1; both saturate at all-ones and never wrap.
REQ-025 With stall_i=1, the table, GHR and statistics SHALL hold their values; combinational outputs SHALL stay valid.
REQ-026 Prediction latency SHALL be 0 cycles (combinational); update latency 1 cycle (visible to reads on the next cycle).
REQ-027 upd_valid_i=0 SHALL leave all state unchanged; if_is_branch_i SHALL have no effect on state.

Reset
REQ-028 When rst_n=0, every counter SHALL asynchronously reset to weakly-not-taken, 2^(CNT_W-1)-1 (01 for CNT_W=2; 0 for CNT_W=1).
REQ-029 When rst_n=0, GHR, branch_cnt_o and miss_cnt_o SHALL reset to 0, so pred_taken_o=0 after reset.
REQ-030 Reset asserted mid-operation SHALL override a simultaneous update; the first update SHALL take effect on the first edge after rst_n deasserts.

Configuration
REQ-031 With GSHARE_EN defined:
  - Index SHALL be the base index XOR the GHR, zero-extended to IDX_W.
  - On each update edge, GHR SHALL shift left and take upd_taken_i into bit 0.
REQ-032 Without GSHARE_EN, the GHR SHALL not exist and the index SHALL be the base index (bimodal).

Structure
REQ-033 Package bp_pkg SHALL hold the counter-update encoding constants and the function computing IDX_W from ENTRIES.
REQ-034 Saturating next-value logic SHALL be a single sub-module, bp_sat_update (inputs: count, taken; output: next count).

Verification (ENTRIES=16, CNT_W=2, STAT_W=32)
REQ-035 Reset, then if_pc_i=0x40 with if_is_branch_i=1 -> pred_idx_o=0, pred_taken_o=0.
REQ-036 Taken updates at idx 3: two -> counter 11 and pc 0x0C predicts taken; a third stays 11; one not-taken -> 10, still taken.
REQ-037 Two not-taken updates at idx 5 from reset -> counter 00 (saturated); pred_taken_o=0.
REQ-038 upd_valid_i=1, upd_taken_i=1, upd_pred_i=0 -> mispredict_o=1 that cycle; next cycle branch_cnt_o=1, miss_cnt_o=1. The same update with stall_i=1 -> counters and table unchanged.
REQ-039 GSHARE_EN: updates taken, taken (GHR=0011), then if_pc_i=0x00 -> pred_idx_o=3.
REQ-040 rst_n pulsed low after idx 3 reaches 11 -> counter returns to 01 and statistics read 0 without a clock edge.
